micro_sequencer: RTL
====================

# micro_sequencer

Microprogrammed control sequencer that drives the processor's register unit. Holds the micro-program counter, addresses a synchronous microcode ROM, and decodes each 36-bit microword into C-bus write enables, B-bus mux select, increment strobes, IR load, memory strobes and ALU op. Computes the next micro-address from the sequencing field, the IR dispatch address and the ALU zero flag. Stalls on memory handshakes.

## Interface
- FETCH_ADDR, 6'd0, micro-address of the fetch routine; used for reset and END
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rom_addr  out  6  address to synchronous microcode ROM; ROM registers it on clk and presents data next cycle
- rom_data  in  36  microword at the address latched on the previous edge
- ir_dispatch  in  6  dispatch address from the instruction register
- z_flag  in  1  ALU zero flag, sampled combinationally
- mem_ready  in  1  memory done; high completes the current mem_read/mem_write
- C_bus_ctrl_sig  out  10  register write enables: [9] PC, [8] RA, [7] RB, [6] RC, [5] R1, [4] R2, [3] R3, [2] DR, [1] AR, [0] AC
- select  out  4  B-bus mux select
- PC_INC, AC_INC, RA_INC, RB_INC, RC_INC  out  1 each  increment strobes
- LDIR  out  1  load IR from DR
- mem_read, mem_write  out  1 each  memory strobes
- alu_op  out  4  ALU operation
- upc  out  6  address of the microword currently executing
- halted  out  1  high in HALT

## Operation
- Microword fields: [35:26] C_bus_ctrl_sig, [25:22] select, [21:17] PC/AC/RA/RB/RC_INC (MSB = PC), [16] LDIR, [15] mem_read, [14] mem_write, [13:10] alu_op, [9] reserved (ignored), [8:6] seq, [5:0] jaddr.
- seq encoding, giving the next address: 0 NEXT = upc+1, wrapping 63->0. 1 JUMP = jaddr. 2 DISPATCH = ir_dispatch. 3 BRZ = jaddr if z_flag else upc+1. 4 BRNZ = jaddr if !z_flag else upc+1. 5 END = FETCH_ADDR. 6 HALT. 7 behaves as NEXT.
- States: FILL, RUN, WAIT, HALT.
  - FILL: entered on reset. rom_addr = FETCH_ADDR; all outputs 0. Next edge goes to RUN with upc <= FETCH_ADDR.
  - RUN: outputs decoded from rom_data.
    - If mem_read or mem_write is set and mem_ready = 0: go to WAIT. rom_addr = upc. Only the mem strobes and alu_op are driven; C_bus, INC and LDIR are forced 0.
    - Otherwise: rom_addr = next address, and upc <= rom_addr on the edge.
    - seq = HALT: all strobes fire this cycle, then the edge goes to HALT.
  - WAIT: same output gating as a stalled RUN, with rom_addr = upc. When mem_ready = 1, all fields fire and the sequencer advances exactly as in RUN.
  - HALT: all outputs 0, halted = 1, rom_addr = upc. Only rst exits HALT.
- Reset values: C_bus_ctrl_sig, select, INC strobes, LDIR, mem strobes, alu_op and halted are all 0. upc = FETCH_ADDR. rom_addr = FETCH_ADDR.
- Asynchronous reset mid-operation (including WAIT or HALT): outputs zero immediately and the sequencer returns to FILL. A pending memory access is abandoned.

## Timing
- Reset released before edge E1: FILL->RUN at E1. Microword FETCH_ADDR drives outputs between E1 and E2; the register unit acts on them at E2.
- Throughput is one microword per cycle with no bubbles. The next address is combinational from rom_data, ir_dispatch and z_flag, so the ROM sees it at the same edge that upc updates.
- Branch decision uses z_flag in the cycle the branch microword executes.
- Memory stall adds one cycle per cycle of mem_ready = 0. A microword whose mem_ready is already high on its first cycle costs no extra cycle.
- mem_ready is ignored when neither mem strobe is set.

## Test plan
- Reset: hold rst, load ROM word 0 = C_bus 10'h200 with seq NEXT. Required: all outputs 0 and rom_addr = 0 during reset. After E1: upc = 0 and C_bus_ctrl_sig = 10'h200. After E2: upc = 1.
- NEXT chain and wrap: words 62 and 63 use NEXT. Required: upc goes 62 -> 63 -> 0.
- Dispatch and return: word seq = DISPATCH with ir_dispatch = 6'h15. Required: next upc = 6'h15. Word 6'h15 seq = END -> next upc = FETCH_ADDR.
- Conditional branch: BRZ with jaddr = 6'h20 at upc 5. With z_flag = 1, required upc = 6'h20. With z_flag = 0, required upc = 6.
- Memory stall: word with mem_read = 1 and C_bus DR bit set; mem_ready = 0 for 3 cycles, then 1. Required during the stall: mem_read = 1, C_bus_ctrl_sig = 0, upc stable, rom_addr = upc. Ready cycle: C_bus_ctrl_sig = 10'h004, then upc advances. Total 4 cycles for the word.
- HALT and reset abort: seq = HALT word. Required: halted = 1 and outputs 0 thereafter, ignoring ir_dispatch and z_flag changes. Assert rst mid-cycle during a WAIT. Required: outputs 0 before the next edge and restart from FETCH_ADDR.

Source files
------------

// File: rtl/micro_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : micro_sequencer
// Purpose  : Microprogrammed control sequencer. Holds the micro-program
//            counter, addresses a synchronous microcode ROM and decodes each
//            36-bit microword into register-unit controls. Stalls on memory
//            handshakes and stops in HALT until reset.
// Ports    : clk, rst (async, active-high)
//            rom_addr (o,6)  / rom_data (i,36)  - synchronous microcode ROM
//            ir_dispatch (i,6), z_flag (i), mem_ready (i)
//            C_bus_ctrl_sig (o,10), select (o,4), PC/AC/RA/RB/RC_INC (o),
//            LDIR, mem_read, mem_write (o), alu_op (o,4), upc (o,6),
//            halted (o)
// Revision : 1.0 - initial release
// ============================================================================
module micro_sequencer #(
  parameter logic [5:0] FETCH_ADDR = 6'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [5:0]  rom_addr,
  input  logic [35:0] rom_data,
  input  logic [5:0]  ir_dispatch,
  input  logic        z_flag,
  input  logic        mem_ready,
  output logic [9:0]  C_bus_ctrl_sig,
  output logic [3:0]  select,
  output logic        PC_INC,
  output logic        AC_INC,
  output logic        RA_INC,
  output logic        RB_INC,
  output logic        RC_INC,
  output logic        LDIR,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  alu_op,
  output logic [5:0]  upc,
  output logic        halted
);

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [2:0] SEQ_NEXT     = 3'd0;
  localparam logic [2:0] SEQ_JUMP     = 3'd1;
  localparam logic [2:0] SEQ_DISPATCH = 3'd2;
  localparam logic [2:0] SEQ_BRZ      = 3'd3;
  localparam logic [2:0] SEQ_BRNZ     = 3'd4;
  localparam logic [2:0] SEQ_END      = 3'd5;
  localparam logic [2:0] SEQ_HALT     = 3'd6;

  state_t      state_q;
  logic [5:0]  upc_q;
  logic [5:0]  upc_d;
  logic [5:0]  upc_inc;

  // Microword fields
  logic [9:0]  f_cbus;
  logic [3:0]  f_sel;
  logic [4:0]  f_inc;
  logic        f_ldir;
  logic        f_mrd;
  logic        f_mwr;
  logic [3:0]  f_alu;
  logic [2:0]  f_seq;
  logic [5:0]  f_jaddr;
  logic        reserved_unused;

  logic        active;
  logic        stall;
  logic        fire;

  assign f_cbus          = rom_data[35:26];
  assign f_sel           = rom_data[25:22];
  assign f_inc           = rom_data[21:17];
  assign f_ldir          = rom_data[16];
  assign f_mrd           = rom_data[15];
  assign f_mwr           = rom_data[14];
  assign f_alu           = rom_data[13:10];
  assign reserved_unused = rom_data[9];
  assign f_seq           = rom_data[8:6];
  assign f_jaddr         = rom_data[5:0];

  // rom_data is only meaningful while executing (RUN or WAIT)
  assign active  = (state_q == S_RUN) || (state_q == S_WAIT);
  // mem_ready only matters when the microword actually requests memory
  assign stall   = active && (f_mrd || f_mwr) && !mem_ready;
  assign fire    = active && !stall;
  assign upc_inc = upc_q + 6'd1;   // natural 6-bit wrap 63 -> 0

  always_comb begin
    upc_d = upc_inc;
    case (f_seq)
      SEQ_NEXT:     upc_d = upc_inc;
      SEQ_JUMP:     upc_d = f_jaddr;
      SEQ_DISPATCH: upc_d = ir_dispatch;
      SEQ_BRZ:      upc_d = z_flag  ? f_jaddr : upc_inc;
      SEQ_BRNZ:     upc_d = !z_flag ? f_jaddr : upc_inc;
      SEQ_END:      upc_d = FETCH_ADDR;
      SEQ_HALT:     upc_d = upc_q;  // halting word keeps the ROM pointed at itself
      default:      upc_d = upc_inc;
    endcase
  end

  // ROM address: during a stall re-present the current word so rom_data
  // stays valid for the whole memory handshake.
  always_comb begin
    rom_addr = FETCH_ADDR;
    case (state_q)
      S_FILL:         rom_addr = FETCH_ADDR;
      S_HALT:         rom_addr = upc_q;
      S_RUN, S_WAIT:  rom_addr = stall ? upc_q : upc_d;
      default:        rom_addr = FETCH_ADDR;
    endcase
  end

  // Register-unit controls only fire on the completing cycle of a word;
  // memory strobes and ALU op are held for the whole handshake.
  assign C_bus_ctrl_sig = fire ? f_cbus : 10'd0;
  assign select         = fire ? f_sel  : 4'd0;
  assign PC_INC         = fire & f_inc[4];
  assign AC_INC         = fire & f_inc[3];
  assign RA_INC         = fire & f_inc[2];
  assign RB_INC         = fire & f_inc[1];
  assign RC_INC         = fire & f_inc[0];
  assign LDIR           = fire & f_ldir;
  assign mem_read       = active & f_mrd;
  assign mem_write      = active & f_mwr;
  assign alu_op         = active ? f_alu : 4'd0;
  assign upc            = upc_q;
  assign halted         = (state_q == S_HALT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FILL;
      upc_q   <= FETCH_ADDR;
    end else begin
      case (state_q)
        S_FILL: begin
          state_q <= S_RUN;
          upc_q   <= FETCH_ADDR;
        end
        S_RUN, S_WAIT: begin
          if (stall) begin
            state_q <= S_WAIT;
          end else if (f_seq == SEQ_HALT) begin
            state_q <= S_HALT;
          end else begin
            state_q <= S_RUN;
            upc_q   <= rom_addr;
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule
`default_nettype wire
